// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the unified memory port arbiter: FSM state encoding,
//   the request-field bundle that is muxed onto the memory port, and the
//   default bus widths used by the interface and the arbiter.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_DATA_W = 32;
    localparam int MEM_ARB_STRB_W = MEM_ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        MEM_ARB__IDLE     = 2'd0,
        MEM_ARB__GNT_CORE = 2'd1,
        MEM_ARB__GNT_HOST = 2'd2
    } mem_arb_state_t;

    // Fields of one access as presented by a requester.
    typedef struct packed {
        logic [MEM_ARB_STRB_W-1:0] we;
        logic [MEM_ARB_ADDR_W-1:0] addr;
        logic [MEM_ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    // An access with no byte strobes set is a read.
    function automatic logic mem_arb_is_read(input logic [MEM_ARB_STRB_W-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   One requester's side of the shared memory port.
//   master : the requester (core or host) - drives req/we/addr/wdata,
//            receives gnt/rvalid/rdata.
//   slave  : the arbiter - the reverse directions.
//   req    : access request, held with fields stable until gnt
//   we     : byte write strobes, all zero = read
//   addr   : byte address
//   wdata  : write data
//   gnt    : access performed at the end of this cycle
//   rvalid : read data valid (cycle after a read grant)
//   rdata  : read data, holds last value when rvalid is low
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
);

    logic                req;
    logic [DATA_W/8-1:0] we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                gnt;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_port_arbiter_perf.sv
// -----------------------------------------------------------------------------
// mem_arb_perf
//   Performance counters for the memory port arbiter. Only compiled when
//   MEM_ARB_PERF_EN is defined.
//   clk, reset        : clock, asynchronous active-high reset
//   i_core_req        : core request
//   i_core_gnt        : core grant
//   i_host_gnt        : host grant
//   o_core_grants     : number of core grants (wraps)
//   o_host_grants     : number of host grants (wraps)
//   o_core_stall      : cycles with core request pending but not granted (wraps)
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_core_req,
    input  logic        i_core_gnt,
    input  logic        i_host_gnt,
    output logic [31:0] o_core_grants,
    output logic [31:0] o_host_grants,
    output logic [31:0] o_core_stall
);

    logic [31:0] r_core_grants;
    logic [31:0] r_host_grants;
    logic [31:0] r_core_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_grants <= '0;
            r_host_grants <= '0;
            r_core_stall  <= '0;
        end else begin
            if (i_core_gnt)
                r_core_grants <= r_core_grants + 32'd1;
            if (i_host_gnt)
                r_host_grants <= r_host_grants + 32'd1;
            if (i_core_req && !i_core_gnt)
                r_core_stall <= r_core_stall + 32'd1;
        end
    end

    assign o_core_grants = r_core_grants;
    assign o_host_grants = r_host_grants;
    assign o_core_stall  = r_core_stall;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single unified instruction/data memory port between the
//   multicycle core and a host requester (loader / debug). Registered FSM
//   with fixed core priority and a bounded host-starvation guard: after
//   CORE_MAX_RUN consecutive core grants while the host waits, one host
//   grant is forced. Back-to-back requests get one access per cycle; read
//   data returns the cycle after the grant.
//
//   Optional feature macro: MEM_ARB_PERF_EN adds the perf_* counter outputs.
//
//   Parameters
//     ADDR_W, DATA_W  bus widths; must match the package widths
//     CORE_MAX_RUN    max consecutive core grants while host waits (>= 1)
//   Ports
//     clk, reset      clock, asynchronous active-high reset
//     core_if, host_if requester interfaces (slave side)
//     mem_addr/mem_wd/mem_we  to the memory port; mem_we nonzero only in
//                     a write grant
//     mem_rd          read data, valid the cycle after the address
//     busy            FSM not idle
//     perf_core_grants/perf_host_grants/perf_core_stall (MEM_ARB_PERF_EN)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MEM_ARB_ADDR_W,
    parameter int DATA_W       = MEM_ARB_DATA_W,
    parameter int CORE_MAX_RUN = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   core_if,
    mem_port_arbiter_if.slave   host_if,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wd,
    output logic [DATA_W/8-1:0] mem_we,
    input  logic [DATA_W-1:0]   mem_rd,
    output logic                busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_core_grants,
    output logic [31:0]         perf_host_grants,
    output logic [31:0]         perf_core_stall
`endif
);

    localparam int             CNT_W   = $clog2(CORE_MAX_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(CORE_MAX_RUN);

    mem_arb_state_t    r_state;
    mem_arb_state_t    w_next_state;
    logic [CNT_W-1:0]  r_run_cnt;
    logic              w_force_host;

    mem_req_t          w_core_fields;
    mem_req_t          w_host_fields;
    mem_req_t          w_sel;
    logic              w_core_gnt;
    logic              w_host_gnt;

    logic              r_core_rvalid;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    assign w_core_fields = '{we: core_if.we, addr: core_if.addr, wdata: core_if.wdata};
    assign w_host_fields = '{we: host_if.we, addr: host_if.addr, wdata: host_if.wdata};

    assign w_force_host = host_if.req && (r_run_cnt == RUN_MAX);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= MEM_ARB__IDLE;
        else
            r_state <= w_next_state;
    end

    // ----------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next_state = MEM_ARB__IDLE;
        if (core_if.req && !w_force_host)
            w_next_state = MEM_ARB__GNT_CORE;
        else if (host_if.req)
            w_next_state = MEM_ARB__GNT_HOST;
    end

    // -------------------------------------------------------------- outputs
    // A grant state only performs the access if its requester still holds
    // req; otherwise the address is shown but no strobe and no grant.
    always_comb begin
        w_sel      = '0;
        w_core_gnt = 1'b0;
        w_host_gnt = 1'b0;
        unique case (r_state)
            MEM_ARB__GNT_CORE: begin
                w_sel      = w_core_fields;
                w_core_gnt = core_if.req;
            end
            MEM_ARB__GNT_HOST: begin
                w_sel      = w_host_fields;
                w_host_gnt = host_if.req;
            end
            default: ;
        endcase
    end

    assign mem_addr = w_sel.addr;
    assign mem_wd   = w_sel.wdata;
    assign mem_we   = (w_core_gnt || w_host_gnt) ? w_sel.we : '0;
    assign busy     = (r_state != MEM_ARB__IDLE);

    assign core_if.gnt = w_core_gnt;
    assign host_if.gnt = w_host_gnt;

    // ------------------------------------------------------ starvation guard
    // The count advances when a core grant is scheduled, so the forced host
    // slot follows immediately after the CORE_MAX_RUN-th consecutive core
    // grant rather than one grant later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_run_cnt <= '0;
        else if (!host_if.req || (w_next_state == MEM_ARB__GNT_HOST))
            r_run_cnt <= '0;
        else if ((w_next_state == MEM_ARB__GNT_CORE) && (r_run_cnt != RUN_MAX))
            r_run_cnt <= r_run_cnt + 1'b1;
    end

    // ------------------------------------------------------------ read return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_gnt && mem_arb_is_read(w_sel.we);
            r_host_rvalid <= w_host_gnt && mem_arb_is_read(w_sel.we);
        end
    end

    // Memory data arrives in the rvalid cycle itself, so it is passed straight
    // through then and captured so rdata holds afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            if (r_core_rvalid)
                r_core_rdata <= mem_rd;
            if (r_host_rvalid)
                r_host_rdata <= mem_rd;
        end
    end

    assign core_if.rvalid = r_core_rvalid;
    assign host_if.rvalid = r_host_rvalid;
    assign core_if.rdata  = r_core_rvalid ? mem_rd : r_core_rdata;
    assign host_if.rdata  = r_host_rvalid ? mem_rd : r_host_rdata;

    // ---------------------------------------------------------- perf counters
`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk           (clk),
        .reset         (reset),
        .i_core_req    (core_if.req),
        .i_core_gnt    (w_core_gnt),
        .i_host_gnt    (w_host_gnt),
        .o_core_grants (perf_core_grants),
        .o_host_grants (perf_host_grants),
        .o_core_stall  (perf_core_stall)
    );
`endif

endmodule
